// File: rtl/sap_1_pkg.sv
// Shared SAP-1 controller definitions: opcodes, control-word bit positions, microcode words.
// Read by the controller top; early-end behaviour is selected there by SAP_1_CTRL_EARLY_END_EN.
package sap_1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int unsigned CON_W = 12;
    typedef logic [CON_W-1:0] con_t;

    // Bit positions inside CON, MSB first; *_N bits are active low.
    localparam int unsigned CON_CP   = 11;
    localparam int unsigned CON_EP   = 10;
    localparam int unsigned CON_LM_N = 9;
    localparam int unsigned CON_CE_N = 8;
    localparam int unsigned CON_LI_N = 7;
    localparam int unsigned CON_EI_N = 6;
    localparam int unsigned CON_LA_N = 5;
    localparam int unsigned CON_EA   = 4;
    localparam int unsigned CON_SU   = 3;
    localparam int unsigned CON_EU   = 2;
    localparam int unsigned CON_LB_N = 1;
    localparam int unsigned CON_LO_N = 0;

    localparam con_t CON_NOP = 12'h3E3;

    localparam con_t CW_FETCH_T1 = 12'h5E3;
    localparam con_t CW_FETCH_T2 = 12'hBE3;
    localparam con_t CW_FETCH_T3 = 12'h263;

    localparam con_t CW_LDA_T4 = 12'h1A3;
    localparam con_t CW_LDA_T5 = 12'h2C3;
    localparam con_t CW_LDA_T6 = CON_NOP;
    localparam con_t CW_ADD_T4 = 12'h1A3;
    localparam con_t CW_ADD_T5 = 12'h2E1;
    localparam con_t CW_ADD_T6 = 12'h3C7;
    localparam con_t CW_SUB_T4 = 12'h1A3;
    localparam con_t CW_SUB_T5 = 12'h2E1;
    localparam con_t CW_SUB_T6 = 12'h3CF;
    localparam con_t CW_OUT_T4 = 12'h3F2;
    localparam con_t CW_OUT_T5 = CON_NOP;
    localparam con_t CW_OUT_T6 = CON_NOP;
    localparam con_t CW_HLT_T4 = CON_NOP;

    typedef enum logic [5:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } ring_state_e;

    function automatic logic is_known_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/sap_1_ring_counter.sv
// Six-state one-hot T-state ring with synchronous clear, hold and restart-to-T1.
// Priority: clear, then hold, then restart, then normal advance.
module sap_1_ring_counter
    import sap_1_pkg::*;
(
    input  logic        clk_i,
    input  logic        clr_i,
    input  logic        hold_i,
    input  logic        restart_i,
    output ring_state_e t_o
);

    ring_state_e state_q, state_d;

    always_comb begin
        state_d = StT1;
        case (state_q)
            StT1:    state_d = StT2;
            StT2:    state_d = StT3;
            StT3:    state_d = StT4;
            StT4:    state_d = StT5;
            StT5:    state_d = StT6;
            StT6:    state_d = StT1;
            default: state_d = StT1; // recover from any non-one-hot value
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= StT1;
        end else if (hold_i) begin
            state_q <= state_q;
        end else if (restart_i) begin
            state_q <= StT1;
        end else begin
            state_q <= state_d;
        end
    end

    assign t_o = state_q;

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: T-state ring plus opcode decode into the 12-bit control word.
// Define SAP_1_CTRL_EARLY_END_EN to skip trailing NOP T-states (variable machine cycle).
module sap_1_controller_sequencer
    import sap_1_pkg::*;
(
    input  logic        Clk,
    input  logic        Clr,
    input  logic [3:0]  opcode,
    output logic [11:0] CON,
    output logic        HLT,
    output logic [5:0]  T
);

    ring_state_e t_state;
    logic        hlt_q;
    logic        halt_set;
    logic        early_end;

    // Halt is decided only in T4; the ring is held on that same edge so it freezes at T4.
    assign halt_set = (t_state == StT4) && (opcode == OP_HLT);

`ifdef SAP_1_CTRL_EARLY_END_EN
    always_comb begin
        early_end = 1'b0;
        if (t_state == StT5 && opcode == OP_LDA) begin
            early_end = 1'b1;
        end else if (t_state == StT4 && (opcode == OP_OUT || !is_known_op(opcode))) begin
            early_end = 1'b1;
        end
    end
`else
    assign early_end = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Clr) begin
            hlt_q <= 1'b0;
        end else if (halt_set) begin
            hlt_q <= 1'b1;
        end
    end

    sap_1_ring_counter u_ring (
        .clk_i     (Clk),
        .clr_i     (Clr),
        .hold_i    (hlt_q | halt_set),
        .restart_i (early_end),
        .t_o       (t_state)
    );

    always_comb begin
        CON = CON_NOP;
        if (!Clr && !hlt_q) begin
            case (t_state)
                StT1: CON = CW_FETCH_T1;
                StT2: CON = CW_FETCH_T2;
                StT3: CON = CW_FETCH_T3;
                StT4: begin
                    case (opcode)
                        OP_LDA:  CON = CW_LDA_T4;
                        OP_ADD:  CON = CW_ADD_T4;
                        OP_SUB:  CON = CW_SUB_T4;
                        OP_OUT:  CON = CW_OUT_T4;
                        OP_HLT:  CON = CW_HLT_T4;
                        default: CON = CON_NOP;
                    endcase
                end
                StT5: begin
                    case (opcode)
                        OP_LDA:  CON = CW_LDA_T5;
                        OP_ADD:  CON = CW_ADD_T5;
                        OP_SUB:  CON = CW_SUB_T5;
                        OP_OUT:  CON = CW_OUT_T5;
                        default: CON = CON_NOP;
                    endcase
                end
                StT6: begin
                    case (opcode)
                        OP_LDA:  CON = CW_LDA_T6;
                        OP_ADD:  CON = CW_ADD_T6;
                        OP_SUB:  CON = CW_SUB_T6;
                        OP_OUT:  CON = CW_OUT_T6;
                        default: CON = CON_NOP;
                    endcase
                end
                default: CON = CON_NOP;
            endcase
        end
    end

    assign T   = t_state;
    assign HLT = hlt_q;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Bench for sap_1_controller_sequencer: per-cycle vector table checked through a scoreboard queue.
// Expectations follow SAP_1_CTRL_EARLY_END_EN when it is defined for the build.
module tb_sap_1_controller_sequencer;

    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic [3:0]  opcode = 4'b0000;
    logic [11:0] CON;
    logic        HLT;
    logic [5:0]  T;

    sap_1_controller_sequencer dut (
        .Clk    (Clk),
        .Clr    (Clr),
        .opcode (opcode),
        .CON    (CON),
        .HLT    (HLT),
        .T      (T)
    );

    always #5 Clk = ~Clk;

    // One row per clock cycle: inputs held during the cycle, outputs expected during it.
    typedef struct {
        logic        clr;
        logic [3:0]  op;
        logic [5:0]  t;
        logic        hlt;
        logic [11:0] con;
        string       name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic clr, input logic [3:0] op, input logic [5:0] t,
                                input logic hlt, input logic [11:0] con, input string name);
        vec_t v;
        v.clr  = clr;
        v.op   = op;
        v.t    = t;
        v.hlt  = hlt;
        v.con  = con;
        v.name = name;
        return v;
    endfunction

    function automatic void add_instr(input logic [3:0] op, input string name);
        logic [11:0] w[6];
        int          len;
        w[0] = 12'h5E3;
        w[1] = 12'hBE3;
        w[2] = 12'h263;
        case (op)
            4'b0000: begin w[3] = 12'h1A3; w[4] = 12'h2C3; w[5] = 12'h3E3; end
            4'b0001: begin w[3] = 12'h1A3; w[4] = 12'h2E1; w[5] = 12'h3C7; end
            4'b0010: begin w[3] = 12'h1A3; w[4] = 12'h2E1; w[5] = 12'h3CF; end
            4'b1110: begin w[3] = 12'h3F2; w[4] = 12'h3E3; w[5] = 12'h3E3; end
            default: begin w[3] = 12'h3E3; w[4] = 12'h3E3; w[5] = 12'h3E3; end
        endcase
        len = 6;
`ifdef SAP_1_CTRL_EARLY_END_EN
        case (op)
            4'b0000:          len = 5;
            4'b0001, 4'b0010: len = 6;
            default:          len = 4;
        endcase
`endif
        for (int i = 0; i < len; i++) begin
            vecs.push_back(mk(1'b0, op, 6'b000001 << i, 1'b0, w[i], name));
        end
    endfunction

    task automatic check(input string what, input string name, input int idx,
                         input logic [11:0] got, input logic [11:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s %s[%0d]: got %h want %h", what, name, idx, got, want);
        end
    endtask

    int row = 0;

    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge Clk);
        #1;
        Clr    = v.clr;
        opcode = v.op;
        sb.push_back(v);
        @(negedge Clk);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard row %0d: got empty queue want one entry", row);
        end else begin
            e = sb.pop_front();
            check("T",   e.name, row, {6'b0, T},    {6'b0, e.t});
            check("HLT", e.name, row, {11'b0, HLT}, {11'b0, e.hlt});
            check("CON", e.name, row, CON,          e.con);
        end
        row++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs.push_back(mk(1'b1, 4'h0, 6'b000001, 1'b0, 12'h3E3, "reset"));
        vecs.push_back(mk(1'b1, 4'h0, 6'b000001, 1'b0, 12'h3E3, "reset"));
        add_instr(4'b0000, "lda");
        add_instr(4'b0000, "lda_wrap");
        add_instr(4'b0001, "add");
        add_instr(4'b0010, "sub");
        add_instr(4'b1110, "out");
        add_instr(4'b0111, "unknown");
        add_instr(4'b0001, "add_again");

        foreach (vecs[i]) apply(vecs[i]);

        // Halt: set on the edge that ends T4, then frozen with a forced NOP whatever the opcode.
        apply(mk(1'b0, 4'hF, 6'b000001, 1'b0, 12'h5E3, "hlt"));
        apply(mk(1'b0, 4'hF, 6'b000010, 1'b0, 12'hBE3, "hlt"));
        apply(mk(1'b0, 4'hF, 6'b000100, 1'b0, 12'h263, "hlt"));
        apply(mk(1'b0, 4'hF, 6'b001000, 1'b0, 12'h3E3, "hlt"));
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            op = (i % 3 == 0) ? 4'hE : ((i % 3 == 1) ? 4'h0 : 4'h1);
            apply(mk(1'b0, op, 6'b001000, 1'b1, 12'h3E3, "halted"));
        end
        apply(mk(1'b1, 4'h1, 6'b001000, 1'b1, 12'h3E3, "halt_clr"));

        // Restart after clear, then a Clr pulse in T5 of ADD.
        apply(mk(1'b0, 4'h1, 6'b000001, 1'b0, 12'h5E3, "mid_rst"));
        apply(mk(1'b0, 4'h1, 6'b000010, 1'b0, 12'hBE3, "mid_rst"));
        apply(mk(1'b0, 4'h1, 6'b000100, 1'b0, 12'h263, "mid_rst"));
        apply(mk(1'b0, 4'h1, 6'b001000, 1'b0, 12'h1A3, "mid_rst"));
        apply(mk(1'b1, 4'h1, 6'b010000, 1'b0, 12'h3E3, "mid_rst"));
        apply(mk(1'b0, 4'h1, 6'b000001, 1'b0, 12'h5E3, "mid_rst"));
        apply(mk(1'b0, 4'h1, 6'b000010, 1'b0, 12'hBE3, "mid_rst"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
